// File: rtl/spike_pushback_buffer.sv
// spike_pushback_buffer: captures output spike addresses into a first-word-fall-through
// FIFO and drains them to the host. It also counts accepted and dropped spikes for the
// current inference, and flags completion once the inference has ended and the FIFO is empty.
//
// Handshake: an event transfers on a rising clk edge when evt_valid_o && evt_ready_i.
// evt_valid_o does not depend on evt_ready_i. evt_addr_o is stable while evt_valid_o is
// high and no transfer occurs. evt_ready_i has no effect while evt_valid_o is low.
module spike_pushback_buffer #(
    parameter int M     = 8,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     spike_pushback_i,
    input  logic [M-1:0]             spike_pushback_addr_i,
    input  logic                     inference_done_i,
    input  logic                     clear_i,
    output logic                     evt_valid_o,
    input  logic                     evt_ready_i,
    output logic [M-1:0]             evt_addr_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic [CNT_W-1:0]         spike_count_o,
    output logic [CNT_W-1:0]         drop_count_o,
    output logic                     overflow_o,
    output logic                     done_o,
    output logic [1:0]               fsm_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [M-1:0]    mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            done_prev;
    logic            done_q;
    logic            full;
    logic            accept;
    logic            push;
    logic            pop;
    logic            drop;
    logic            done_rise;

    // Datapath qualifiers. A push while full is only taken when the head leaves in the same cycle.
    always_comb begin
        full        = (count == FULL_LVL);
        evt_valid_o = (count != '0);
        pop         = evt_valid_o && evt_ready_i;
        accept      = spike_pushback_i && (state != DONE);
        push        = accept && (!full || pop);
        drop        = accept && full && !pop;
        done_rise   = inference_done_i && !done_prev;
        // Gate the head so the bus reads zero when empty, since the array itself has no reset.
        evt_addr_o  = evt_valid_o ? mem[rd_ptr] : '0;
    end

    // Storage array. It needs no reset because nothing reads it while count is zero.
    always_ff @(posedge clk_i) begin
        if (!clear_i && push) begin
            mem[wr_ptr] <= spike_pushback_addr_i;
        end
    end

    // Pointers, occupancy, and the per-inference counters. A clear takes priority over any push or pop.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            spike_count_o <= '0;
            drop_count_o  <= '0;
            overflow_o    <= 1'b0;
        end else if (clear_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            spike_count_o <= '0;
            drop_count_o  <= '0;
            overflow_o    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (spike_count_o != CNT_MAX) begin
                    spike_count_o <= spike_count_o + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_count_o != CNT_MAX) begin
                    drop_count_o <= drop_count_o + 1'b1;
                end
            end
        end
    end

    // Next-state logic for the inference lifecycle.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (done_rise) state_nxt = DRAIN;
            DRAIN:   if ((count == '0) && !spike_pushback_i) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = RUN;
        endcase
    end

    // State register, registered done flag, and the inference_done edge detector.
    // On a clear, the edge detector loads the live level. A level held high across the clear
    // therefore does not count as a new rising edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= RUN;
            done_q    <= 1'b0;
            done_prev <= 1'b0;
        end else if (clear_i) begin
            state     <= RUN;
            done_q    <= 1'b0;
            done_prev <= inference_done_i;
        end else begin
            state     <= state_nxt;
            done_q    <= (state_nxt == DONE);
            done_prev <= inference_done_i;
        end
    end

    assign done_o       = done_q;
    assign fifo_count_o = count;
    assign fsm_state_o  = state;

endmodule

// File: tb/tb_spike_pushback_buffer.sv
// Directed testbench for spike_pushback_buffer (M=8, DEPTH=16, CNT_W=16).
module tb_spike_pushback_buffer;

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic        clk;
    logic        rst;
    logic        spike;
    logic [7:0]  spike_addr;
    logic        inf_done;
    logic        clear;
    logic        evt_valid;
    logic        evt_ready;
    logic [7:0]  evt_addr;
    logic [4:0]  fifo_count;
    logic [15:0] spike_count;
    logic [15:0] drop_count;
    logic        overflow;
    logic        done;
    logic [1:0]  fsm_state;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] t4_exp [3];

    spike_pushback_buffer #(.M(8), .DEPTH(16), .CNT_W(16)) dut (
        .clk_i                 (clk),
        .rst_i                 (rst),
        .spike_pushback_i      (spike),
        .spike_pushback_addr_i (spike_addr),
        .inference_done_i      (inf_done),
        .clear_i               (clear),
        .evt_valid_o           (evt_valid),
        .evt_ready_i           (evt_ready),
        .evt_addr_o            (evt_addr),
        .fifo_count_o          (fifo_count),
        .spike_count_o         (spike_count),
        .drop_count_o          (drop_count),
        .overflow_o            (overflow),
        .done_o                (done),
        .fsm_state_o           (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"},   32'(evt_valid),   32'd0);
        chk({tag, "_addr"},    32'(evt_addr),    32'd0);
        chk({tag, "_count"},   32'(fifo_count),  32'd0);
        chk({tag, "_spikes"},  32'(spike_count), 32'd0);
        chk({tag, "_drops"},   32'(drop_count),  32'd0);
        chk({tag, "_ovf"},     32'(overflow),    32'd0);
        chk({tag, "_done"},    32'(done),        32'd0);
        chk({tag, "_state"},   32'(fsm_state),   32'(S_RUN));
    endtask

    initial begin
        rst = 1'b1; spike = 1'b0; spike_addr = '0; inf_done = 1'b0;
        clear = 1'b0; evt_ready = 1'b0;
        t4_exp[0] = 8'h01; t4_exp[1] = 8'h02; t4_exp[2] = 8'hF7;

        // reset state
        #2;
        chk_all_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // single spike with FWFT latency of one edge, then one pop
        spike = 1'b1; spike_addr = 8'h2A;
        tick();
        spike = 1'b0;
        chk("t1_valid",  32'(evt_valid),   32'd1);
        chk("t1_addr",   32'(evt_addr),    32'h2A);
        chk("t1_count",  32'(fifo_count),  32'd1);
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        chk("t1_count_after", 32'(fifo_count),  32'd0);
        chk("t1_valid_after", 32'(evt_valid),   32'd0);
        chk("t1_spikes",      32'(spike_count), 32'd1);

        // 20 spikes into a 16-deep FIFO with no consumer, then drain in order
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t2_cleared_spikes", 32'(spike_count), 32'd0);
        for (int i = 0; i < 20; i++) begin
            spike = 1'b1; spike_addr = 8'(i);
            tick();
        end
        spike = 1'b0;
        chk("t2_count",  32'(fifo_count),  32'd16);
        chk("t2_spikes", 32'(spike_count), 32'd16);
        chk("t2_drops",  32'(drop_count),  32'd4);
        chk("t2_ovf",    32'(overflow),    32'd1);
        evt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_valid", 32'(evt_valid), 32'd1);
            chk("t2_drain_addr",  32'(evt_addr),  32'(i));
            tick();
        end
        evt_ready = 1'b0;
        chk("t2_empty", 32'(evt_valid), 32'd0);

        // full FIFO with simultaneous push and pop, order kept across pointer wrap
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 16; i++) begin
            spike = 1'b1; spike_addr = 8'(i);
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            spike      = (k < 24);
            spike_addr = 8'(16 + k);
            evt_ready  = 1'b1;
            if (k == 24) chk("t3_count_full", 32'(fifo_count), 32'd16);
            chk("t3_valid", 32'(evt_valid), 32'd1);
            chk("t3_addr",  32'(evt_addr),  32'(k));
            tick();
        end
        spike = 1'b0; evt_ready = 1'b0;
        chk("t3_count_end", 32'(fifo_count),  32'd0);
        chk("t3_spikes",    32'(spike_count), 32'd40);
        chk("t3_drops",     32'(drop_count),  32'd0);
        chk("t3_ovf",       32'(overflow),    32'd0);

        // final spike arrives with the inference_done rise; done follows the empty FIFO by one cycle
        clear = 1'b1;
        tick();
        clear = 1'b0;
        spike = 1'b1; spike_addr = 8'h01;
        tick();
        spike_addr = 8'h02;
        tick();
        spike_addr = 8'hF7; inf_done = 1'b1;
        tick();
        spike = 1'b0;
        chk("t4_state_drain", 32'(fsm_state),   32'(S_DRAIN));
        chk("t4_count",       32'(fifo_count),  32'd3);
        chk("t4_spikes",      32'(spike_count), 32'd3);
        evt_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t4_done_early", 32'(done),     32'd0);
            chk("t4_addr",       32'(evt_addr), 32'(t4_exp[i]));
            tick();
        end
        chk("t4_empty",        32'(fifo_count), 32'd0);
        chk("t4_done_not_yet", 32'(done),       32'd0);
        tick();
        chk("t4_done",       32'(done),      32'd1);
        chk("t4_state_done", 32'(fsm_state), 32'(S_DONE));
        evt_ready = 1'b0;
        spike = 1'b1; spike_addr = 8'h55;
        tick();
        spike = 1'b0;
        chk("t4_ignored_spikes", 32'(spike_count), 32'd3);
        chk("t4_ignored_drops",  32'(drop_count),  32'd0);
        chk("t4_ignored_count",  32'(fifo_count),  32'd0);

        // reach DONE with overflow set, then clear while inference_done stays high
        inf_done = 1'b0; clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 17; i++) begin
            spike = 1'b1; spike_addr = 8'(i);
            tick();
        end
        spike = 1'b0;
        chk("t5_drops", 32'(drop_count), 32'd1);
        inf_done = 1'b1;
        tick();
        chk("t5_state_drain", 32'(fsm_state), 32'(S_DRAIN));
        evt_ready = 1'b1;
        repeat (16) tick();
        chk("t5_empty",   32'(fifo_count), 32'd0);
        chk("t5_not_done", 32'(done),      32'd0);
        tick();
        evt_ready = 1'b0;
        chk("t5_done", 32'(done),     32'd1);
        chk("t5_ovf",  32'(overflow), 32'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk_all_zero("t5_clear");
        repeat (3) tick();
        chk("t5_no_retrigger_state", 32'(fsm_state), 32'(S_RUN));
        chk("t5_no_retrigger_done",  32'(done),      32'd0);

        // asynchronous reset mid-drain with five entries queued
        inf_done = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            spike = 1'b1; spike_addr = 8'(8'h10 + i);
            tick();
        end
        spike = 1'b0; inf_done = 1'b1;
        tick();
        chk("t6_state_drain", 32'(fsm_state),  32'(S_DRAIN));
        chk("t6_count",       32'(fifo_count), 32'd5);
        evt_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("t6_async_valid", 32'(evt_valid),  32'd0);
        chk("t6_async_count", 32'(fifo_count), 32'd0);
        inf_done = 1'b0; evt_ready = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        chk_all_zero("t6_release");
        tick();
        chk("t6_after_state", 32'(fsm_state), 32'(S_RUN));
        chk("t6_after_valid", 32'(evt_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_pushback_buffer.md
Name: spike_pushback_buffer

Overview:
Sits directly downstream of the spike output stage. It captures each pushed-back output spike address into a first-word-fall-through FIFO and drains the FIFO to the host side over a valid/ready interface. It also counts output spikes for the current inference. It detects end-of-inference from the upstream inference_done flag and raises a completion flag once every captured spike has been drained.

Parameters:
M, 8, neuron address width; matches the upstream spike address width.
DEPTH, 16, FIFO depth in entries; must be a power of 2 and at least 2.
CNT_W, 16, width of the saturating spike and drop counters.

Ports:
clk_i  input  1  core clock; all state updates on the rising edge.
rst_i  input  1  asynchronous, active-high reset.
spike_pushback_i  input  1  one-cycle spike event from the upstream stage.
spike_pushback_addr_i  input  M  neuron address of the spike; valid when spike_pushback_i=1.
inference_done_i  input  1  level from upstream, high when the last neuron index has been reached.
clear_i  input  1  synchronous soft clear that starts a new inference.
evt_valid_o  output  1  FIFO head is valid.
evt_ready_i  input  1  consumer accepts the head this cycle.
evt_addr_o  output  M  FIFO head address.
fifo_count_o  output  $clog2(DEPTH)+1  current FIFO occupancy.
spike_count_o  output  CNT_W  number of spikes accepted this inference (saturating).
drop_count_o  output  CNT_W  number of spikes dropped this inference (saturating).
overflow_o  output  1  sticky flag, set when any spike is dropped.
done_o  output  1  inference complete and FIFO fully drained; level, held until clear.

Behaviour:
- Reset (rst_i=1, asynchronous):
  - FIFO emptied; pointers and counts are 0.
  - evt_valid_o=0, evt_addr_o=0.
  - spike_count_o=0, drop_count_o=0, overflow_o=0, done_o=0.
  - FSM goes to RUN; inference_done edge-detect register is 0.
- Reset mid-operation discards all buffered events with no drain.
- clear_i has the highest synchronous priority. In the cycle it is sampled, it has the same effect as reset on the next edge, and any push or pop in that cycle is ignored.
- Push rule: push = spike_pushback_i && state!=DONE && (!full || pop).
  - A simultaneous push and pop while full is accepted; occupancy is unchanged.
- Drop rule: spike_pushback_i && state!=DONE && full && !pop.
  - drop_count_o increments (saturating at 2^CNT_W-1) and overflow_o sets.
  - spike_count_o does not increment.
- Pop rule: pop = evt_valid_o && evt_ready_i.
  - evt_valid_o = (count != 0).
  - evt_addr_o = mem[rd_ptr], combinational from the registered array (FWFT).
- Latency: a spike pushed at edge N shows on evt_valid_o/evt_addr_o after edge N when the FIFO was empty. There is no bypass path.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. Occupancy is tracked with a separate counter, 0..DEPTH.
- spike_count_o increments on every accepted push and saturates at 2^CNT_W-1.
- FSM states:
  - RUN:
    - Accepts spikes.
    - Rising edge of inference_done_i (registered previous value = 0, current = 1) -> DRAIN.
    - A spike in the same cycle as that edge is still accepted, because upstream asserts done with the final spike.
  - DRAIN:
    - Still accepts spikes; upstream may emit in the following cycles.
    - When the FIFO count is 0 and spike_pushback_i=0 -> DONE.
  - DONE:
    - done_o=1.
    - Further spikes are ignored: not counted, not dropped, and overflow_o is not set.
    - Stays in DONE until clear_i.
  - A level-high inference_done_i held across clear_i does not re-trigger; a new rising edge is required.
- done_o is a registered output, asserted in the cycle after the DRAIN->DONE transition condition is met.
- evt_ready_i asserted while evt_valid_o=0 has no effect.

Test Plan:
- Single spike, addr 0x2A, with evt_ready_i=0 -> after 1 edge, evt_valid_o=1, evt_addr_o=0x2A, fifo_count_o=1; assert ready 1 cycle -> count 0, spike_count_o=1.
- 20 back-to-back spikes, addr 0..19, ready=0, DEPTH=16 -> fifo_count_o=16, spike_count_o=16, drop_count_o=4, overflow_o=1; drain gives addrs 0..15 in order.
- FIFO full with ready=1 and spikes continuing every cycle -> no drops, count stays 16, output order preserved across pointer wrap (addrs 0..39).
- Spike addr 0xF7 together with the inference_done_i rise, 3 entries queued, ready=1 -> done_o rises exactly 1 cycle after the FIFO empties, never earlier; a subsequent spike leaves spike_count_o unchanged.
- clear_i while in DONE with overflow_o=1 -> all counters 0, overflow_o=0, done_o=0, state RUN; inference_done_i still high does not re-enter DRAIN.
- rst_i asserted asynchronously mid-drain with 5 entries queued -> evt_valid_o drops without waiting for a clock edge; all outputs read 0 after release.
